// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: event inputs and phase/score outputs of the Battleship
// turn sequencer. The master side (board logic / keyboard front end) raises
// the event pulses. The slave side (the sequencer) drives the phase strobes,
// the score counters and the timer.
interface turn_sequencer_if;
    logic       start;
    logic       place_done;
    logic       fire_valid;
    logic       fire_hit;
    logic       p1place;
    logic       p2place;
    logic       p1fire;
    logic       p2fire;
    logic       active_player;
    logic       game_over;
    logic       winner;
    logic [4:0] hits_p1;
    logic [4:0] hits_p2;
    logic [5:0] time_left;

    modport master (
        output start, place_done, fire_valid, fire_hit,
        input  p1place, p2place, p1fire, p2fire, active_player,
               game_over, winner, hits_p1, hits_p2, time_left
    );

    modport slave (
        input  start, place_done, fire_valid, fire_hit,
        output p1place, p2place, p1fire, p2fire, active_player,
               game_over, winner, hits_p1, hits_p2, time_left
    );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: game-phase controller for Keyboard Battleship.
// The game runs through placement for P1 and then P2. Fire turns then
// alternate until one player reaches HITS_TO_WIN.
// Optional feature macro: TURN_TIMEOUT_EN. When it is defined, each fire turn
// has a TIMEOUT_SEC budget. A divider counts TICK_DIV+1 clock cycles per
// second. A turn whose budget runs out passes to the other player with no
// hit counted.
// All outputs are decoded from registers only.
module turn_sequencer #(
    parameter int unsigned SHIPS_PER_PLAYER = 5,
    parameter int unsigned HITS_TO_WIN      = 17,
    parameter int unsigned TICK_DIV         = 99999999,
    parameter int unsigned TIMEOUT_SEC      = 30
) (
    input  logic              clk,
    input  logic              rst,
    turn_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        P1_PLACE,
        P2_PLACE,
        P1_FIRE,
        P2_FIRE,
        GAME_OVER
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] place_cnt_q, place_cnt_d;
    logic [4:0] hits_p1_q, hits_p1_d;
    logic [4:0] hits_p2_q, hits_p2_d;
    logic       winner_q, winner_d;
    logic       timeout_expire;

    // State and score registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            place_cnt_q <= '0;
            hits_p1_q   <= '0;
            hits_p2_q   <= '0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            place_cnt_q <= place_cnt_d;
            hits_p1_q   <= hits_p1_d;
            hits_p2_q   <= hits_p2_d;
            winner_q    <= winner_d;
        end
    end

    // Next-state, placement counting and hit scoring
    always_comb begin
        state_d     = state_q;
        place_cnt_d = place_cnt_q;
        hits_p1_d   = hits_p1_q;
        hits_p2_d   = hits_p2_q;
        winner_d    = winner_q;
        unique case (state_q)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    state_d     = P1_PLACE;
                    place_cnt_d = '0;
                    hits_p1_d   = '0;
                    hits_p2_d   = '0;
                    winner_d    = 1'b0;
                end
            end
            P1_PLACE, P2_PLACE: begin
                if (bus.place_done) begin
                    if (place_cnt_q + 4'd1 == 4'(SHIPS_PER_PLAYER)) begin
                        place_cnt_d = '0;
                        state_d     = (state_q == P1_PLACE) ? P2_PLACE : P1_FIRE;
                    end else begin
                        place_cnt_d = place_cnt_q + 4'd1;
                    end
                end
            end
            P1_FIRE: begin
                // A shot takes priority over an expiring timeout in the same cycle
                if (bus.fire_valid) begin
                    state_d = P2_FIRE;
                    if (bus.fire_hit) begin
                        hits_p1_d = hits_p1_q + 5'd1;
                        if (hits_p1_d == 5'(HITS_TO_WIN)) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b0;
                        end
                    end
                end else if (timeout_expire) begin
                    state_d = P2_FIRE;
                end
            end
            P2_FIRE: begin
                if (bus.fire_valid) begin
                    state_d = P1_FIRE;
                    if (bus.fire_hit) begin
                        hits_p2_d = hits_p2_q + 5'd1;
                        if (hits_p2_d == 5'(HITS_TO_WIN)) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b1;
                        end
                    end
                end else if (timeout_expire) begin
                    state_d = P1_FIRE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TURN_TIMEOUT_EN
    logic [31:0] tick_q, tick_d;
    logic [5:0]  sec_q, sec_d;
    logic        in_fire_q, in_fire_d;

    assign in_fire_q = (state_q == P1_FIRE) || (state_q == P2_FIRE);
    assign in_fire_d = (state_d == P1_FIRE) || (state_d == P2_FIRE);

    // The timer expires on the divider wrap that would take the count from 1 to 0
    assign timeout_expire = in_fire_q && (tick_q == TICK_DIV) && (sec_q == 6'd1);

    // Divider and seconds registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            sec_q  <= '0;
        end else begin
            tick_q <= tick_d;
            sec_q  <= sec_d;
        end
    end

    // Every fire-turn change changes state, so a state change into a fire state reloads the timer
    always_comb begin
        tick_d = '0;
        sec_d  = '0;
        if (in_fire_d) begin
            if (state_d != state_q) begin
                sec_d = 6'(TIMEOUT_SEC);
            end else if (tick_q == TICK_DIV) begin
                sec_d = sec_q - 6'd1;
            end else begin
                tick_d = tick_q + 32'd1;
                sec_d  = sec_q;
            end
        end
    end

    assign bus.time_left = sec_q;
`else
    logic unused_cfg;

    assign unused_cfg     = ^{TICK_DIV, TIMEOUT_SEC};
    assign timeout_expire = 1'b0;
    assign bus.time_left  = '0;
`endif

    assign bus.p1place       = (state_q == P1_PLACE);
    assign bus.p2place       = (state_q == P2_PLACE);
    assign bus.p1fire        = (state_q == P1_FIRE);
    assign bus.p2fire        = (state_q == P2_FIRE);
    assign bus.active_player = (state_q == P2_PLACE) || (state_q == P2_FIRE);
    assign bus.game_over     = (state_q == GAME_OVER);
    assign bus.winner        = winner_q;
    assign bus.hits_p1       = hits_p1_q;
    assign bus.hits_p2       = hits_p2_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed bench for turn_sequencer. A phase-level game
// model is checked against the DUT on every falling edge. Literal
// expectations at key points pin both the model and the DUT.
// The bench follows TURN_TIMEOUT_EN in the same way as the design.
module tb_turn_sequencer;

    localparam int SHIPS = 5;
    localparam int WIN   = 4;
    localparam int TDIV  = 3;
    localparam int TSEC  = 2;
`ifdef TURN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    turn_sequencer_if bus ();

    turn_sequencer #(
        .SHIPS_PER_PLAYER (SHIPS),
        .HITS_TO_WIN      (WIN),
        .TICK_DIV         (TDIV),
        .TIMEOUT_SEC      (TSEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: phase 0 idle, 1 placing, 2 firing, 3 over; m_player is whose turn
    int m_phase  = 0;
    int m_player = 0;
    int m_placed = 0;
    int m_hits[2] = '{0, 0};
    int m_winner = 0;
    int m_cyc    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_player = 0; m_placed = 0;
            m_hits[0] = 0; m_hits[1] = 0; m_winner = 0; m_cyc = 0;
        end else begin
            case (m_phase)
                0, 3: if (bus.start) begin
                    m_phase = 1; m_player = 0; m_placed = 0;
                    m_hits[0] = 0; m_hits[1] = 0;
                end
                1: if (bus.place_done) begin
                    m_placed++;
                    if (m_placed == SHIPS) begin
                        m_placed = 0;
                        if (m_player == 0) m_player = 1;
                        else begin m_phase = 2; m_player = 0; m_cyc = 0; end
                    end
                end
                2: begin
                    if (bus.fire_valid) begin
                        if (bus.fire_hit) m_hits[m_player]++;
                        if (m_hits[m_player] == WIN) begin
                            m_phase = 3; m_winner = m_player;
                        end else begin
                            m_player = 1 - m_player; m_cyc = 0;
                        end
                    end else if (TO_EN && (m_cyc + 1 == TSEC * (TDIV + 1))) begin
                        m_player = 1 - m_player; m_cyc = 0;
                    end else begin
                        m_cyc++;
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        chk("p1place", int'(bus.p1place), int'(m_phase == 1 && m_player == 0));
        chk("p2place", int'(bus.p2place), int'(m_phase == 1 && m_player == 1));
        chk("p1fire",  int'(bus.p1fire),  int'(m_phase == 2 && m_player == 0));
        chk("p2fire",  int'(bus.p2fire),  int'(m_phase == 2 && m_player == 1));
        chk("active_player", int'(bus.active_player),
            (m_phase == 1 || m_phase == 2) ? m_player : 0);
        chk("game_over", int'(bus.game_over), int'(m_phase == 3));
        if (m_phase == 3) chk("winner", int'(bus.winner), m_winner);
        chk("hits_p1", int'(bus.hits_p1), m_hits[0]);
        chk("hits_p2", int'(bus.hits_p2), m_hits[1]);
        chk("time_left", int'(bus.time_left),
            (TO_EN && m_phase == 2) ? TSEC - m_cyc / (TDIV + 1) : 0);
    end

    // Inputs change 3 time units after a rising edge. Each call covers one sampling edge.
    task automatic drive(input logic s, input logic pd, input logic fv, input logic fh);
        bus.start = s; bus.place_done = pd; bus.fire_valid = fv; bus.fire_hit = fh;
        @(posedge clk);
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic place_all();
        for (int i = 0; i < 2 * SHIPS; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.place_done = 1'b0; bus.fire_valid = 1'b0; bus.fire_hit = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        chk("rst_p1place", int'(bus.p1place), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        chk("rst_hits_p1", int'(bus.hits_p1), 0);
        chk("rst_time_left", int'(bus.time_left), 0);
        idle(2);
        chk("idle_hold", int'(bus.p1place), 0);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_p1place", int'(bus.p1place), 1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("fire_in_place_ignored", int'(bus.p1place), 1);
        chk("fire_in_place_hits", int'(bus.hits_p1), 0);

        for (int i = 0; i < SHIPS; i++) drive(1'b0, 1'b1, i == 2, i == 2);
        chk("p1_placed_p2place", int'(bus.p2place), 1);
        chk("p1_placed_active", int'(bus.active_player), 1);
        for (int i = 0; i < SHIPS; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("placed_p1fire", int'(bus.p1fire), 1);
        if (TO_EN) chk("fire_entry_time", int'(bus.time_left), TSEC);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_in_fire_ignored", int'(bus.p1fire), 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("miss_p2fire", int'(bus.p2fire), 1);
        chk("miss_hits_p1", int'(bus.hits_p1), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("hit_hits_p2", int'(bus.hits_p2), 1);
        chk("hit_p1fire", int'(bus.p1fire), 1);

`ifdef TURN_TIMEOUT_EN
        idle(4);
        chk("timeout_tick1", int'(bus.time_left), 1);
        idle(3);
        chk("timeout_not_yet", int'(bus.p1fire), 1);
        idle(1);
        chk("timeout_p2fire", int'(bus.p2fire), 1);
        chk("timeout_reload", int'(bus.time_left), TSEC);
        chk("timeout_no_hit", int'(bus.hits_p1), 0);
        idle(7);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("expire_shot_hits_p2", int'(bus.hits_p2), 2);
        chk("expire_single_switch", int'(bus.p1fire), 1);
        chk("expire_reload", int'(bus.time_left), TSEC);
`else
        idle(10000);
        chk("no_timeout_p1fire", int'(bus.p1fire), 1);
        chk("no_timeout_time_left", int'(bus.time_left), 0);
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hit_without_valid", int'(bus.p1fire), 1);

        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, (i % 2) == 0);
        chk("pre_reset_hits_p1", int'(bus.hits_p1), 3);
        chk("pre_reset_p2fire", int'(bus.p2fire), 1);

        rst = 1'b1;
        #1;
        chk("async_rst_p2fire", int'(bus.p2fire), 0);
        chk("async_rst_hits_p1", int'(bus.hits_p1), 0);
        chk("async_rst_active", int'(bus.active_player), 0);
        chk("async_rst_time_left", int'(bus.time_left), 0);
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("post_rst_idle", int'(bus.p1place), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_start", int'(bus.p1place), 1);

        place_all();
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, (i % 2) == 0);
        chk("p1_win_over", int'(bus.game_over), 1);
        chk("p1_win_winner", int'(bus.winner), 0);
        chk("p1_win_strobes", int'({bus.p1place, bus.p2place, bus.p1fire, bus.p2fire}), 0);
        chk("p1_win_hits", int'(bus.hits_p1), WIN);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("over_events_ignored", int'(bus.hits_p1), WIN);
        chk("over_holds", int'(bus.game_over), 1);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_p1place", int'(bus.p1place), 1);
        chk("restart_hits_p1", int'(bus.hits_p1), 0);
        chk("restart_game_over", int'(bus.game_over), 0);

        place_all();
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, (i % 2) == 1);
        chk("p2_win_over", int'(bus.game_over), 1);
        chk("p2_win_winner", int'(bus.winner), 1);
        chk("p2_win_hits", int'(bus.hits_p2), WIN);
        chk("p2_win_active", int'(bus.active_player), 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-phase controller for Keyboard Battleship. It sequences both players through ship placement, then alternating fire turns, up to game over. It drives the `p1place`/`p2place`/`p1fire`/`p2fire` phase strobes that select the seven-segment letter display, and gates which player's keyboard events the board logic accepts. An optional per-turn fire timeout forfeits a stalled turn.

## Interface
Parameters:
- `SHIPS_PER_PLAYER`, default 5: placement events each player must complete (1..15).
- `HITS_TO_WIN`, default 17: hits a player needs to win (1..31).
- `TICK_DIV`, default 99999999: clk cycles per 1 s timeout tick, minus one (100 MHz board clock).
- `TIMEOUT_SEC`, default 30: seconds allowed per fire turn (1..63).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a game.
- `place_done` in 1: single-cycle pulse; the current player has committed one ship.
- `fire_valid` in 1: single-cycle pulse; the current player has fired one shot.
- `fire_hit` in 1: qualifies `fire_valid`; 1 = the shot hit.
- `p1place`, `p2place`, `p1fire`, `p2fire` out 1 each: phase strobes, at most one high.
- `active_player` out 1: 0 = P1, 1 = P2.
- `game_over` out 1: high in GAME_OVER.
- `winner` out 1: 0 = P1, 1 = P2; valid only while `game_over` is high.
- `hits_p1`, `hits_p2` out 5 each: hits scored by each player.
- `time_left` out 6: seconds remaining in the current fire turn.

## Operation
- FSM states are IDLE, P1_PLACE, P2_PLACE, P1_FIRE, P2_FIRE and GAME_OVER. All outputs are decoded from registers only, with no combinational path from any input.
- **IDLE**
  - `start` moves to P1_PLACE and clears the place count, `hits_p1` and `hits_p2`.
- **P1_PLACE / P2_PLACE**
  - Each `place_done` increments the place count.
  - When the increment reaches `SHIPS_PER_PLAYER`, the count clears and the FSM moves on: P1_PLACE goes to P2_PLACE, and P2_PLACE goes to P1_FIRE.
- **P1_FIRE / P2_FIRE**
  - `fire_valid` is always accepted, and `fire_hit` is sampled in the same cycle.
  - On a hit, the shooter's hit counter increments.
  - If the new hit count equals `HITS_TO_WIN`, the FSM goes to GAME_OVER with `winner` set to the shooter.
  - Otherwise the turn passes to the other player's fire state, on a hit or a miss.
- **GAME_OVER**
  - Hit counters and `winner` hold their values.
  - `start` restarts the game exactly as from IDLE.
- **Strobes**
  - `p1place` is high only in P1_PLACE, `p2place` only in P2_PLACE, `p1fire` only in P1_FIRE, `p2fire` only in P2_FIRE.
  - All four strobes are low in IDLE and GAME_OVER.
- **`active_player`**: 1 in P2_PLACE and P2_FIRE, 0 in every other state.
- **Ignored events**
  - `place_done` outside the place states is ignored.
  - `fire_valid` outside the fire states is ignored.
  - `start` outside IDLE and GAME_OVER is ignored.
- **Simultaneous events**
  - When `place_done` and `fire_valid` arrive in the same cycle, only the one relevant to the current state acts.
  - `fire_hit` without `fire_valid` is ignored.
- **Counter wrap**: none. Hit counters stop at `HITS_TO_WIN` because the FSM leaves the fire states.

## Timing
- **Event latency**: an event sampled at rising edge N updates state, counters and outputs at edge N. The change is visible in cycle N+1, a latency of 1 cycle.
- **Reset values**
  - State IDLE.
  - All four strobes 0.
  - `active_player` 0, `game_over` 0, `winner` 0.
  - `hits_p1` 0, `hits_p2` 0, `time_left` 0.
  - Place count, tick divider and second counter 0.
- **Reset mid-game**: `rst` asserted at any time returns the block to the reset values immediately and asynchronously. The FSM stays in IDLE until a `start` arrives after `rst` deasserts.
- **Back-to-back events**: one `place_done` or `fire_valid` per cycle is processed, with no dead cycles. A pulse arriving in the cycle right after a turn change applies to the new state.

## Configuration
`TURN_TIMEOUT_EN` controls the per-turn fire timeout.

With the macro defined:
- On entry to any fire state:
  - `time_left` loads `TIMEOUT_SEC`.
  - The tick divider clears.
- The divider counts 0..`TICK_DIV`. At the cycle where it wraps, `time_left` decrements by 1.
- The decrement that reaches 0 forfeits the turn: the FSM passes to the other fire state with no hit counted, and `time_left` reloads.
- `fire_valid` in the same cycle as the expiring tick takes priority: the shot is processed and the timeout is discarded.
- `time_left` is 0 outside the fire states.

Without the macro:
- No divider or second-counter logic exists.
- `time_left` is tied to 0.
- Fire turns wait indefinitely.

## Test plan
- **Reset**: assert `rst` mid-P2_FIRE with `hits_p1`=3 → same cycle all outputs 0 and state IDLE; after release, `start` → `p1place`=1 one cycle later.
- **Placement**: `start`, then 5 `place_done` pulses back-to-back → `p2place`=1 the cycle after the 5th; 5 more pulses → `p1fire`=1. A `fire_valid` injected during placement → no change.
- **Alternation**: in P1_FIRE, `fire_valid` with `fire_hit`=0 → `p2fire`=1 and `hits_p1`=0; then `fire_valid` with `fire_hit`=1 → `hits_p2`=1 and `p1fire`=1.
- **Win** (`HITS_TO_WIN`=2): P1 hits twice across two turns → `game_over`=1, `winner`=0, all strobes 0; `start` → `p1place`=1 with both hit counters 0.
- **Timeout** (`TURN_TIMEOUT_EN`, `TICK_DIV`=3, `TIMEOUT_SEC`=2): idle in P1_FIRE → `time_left` 2, then 1, then after 8 cycles `p2fire`=1 and `time_left`=2. `fire_valid` on the expiring cycle → shot processed and hits updated, no double turn switch.
- **Macro off**: idle in P1_FIRE for 10⁴ cycles → `p1fire` stays 1 and `time_left`=0.
